// File: rtl/t_group_unpacker.sv
// -----------------------------------------------------------------------------
// t_group_unpacker
//
// Read-back end of the T/V/F spill path. Replays a previously stored column by
// fetching packed SRAM words through the SRAM controller and unpacking every
// group {t, v[VEF_BIT-2:0], f[VEF_BIT-2:0]} into a t/v/f element stream for
// the PE array feeder. Group 0 of each word sits in the least significant bits.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   i_start, i_T_size start pulse and element count (accepted only when idle)
//   o_busy, o_done    busy from accepted start through the done cycle; done pulse
//   o_sram_request    one-cycle request for the next packed word
//   i_request_valid   qualifies i_request_data (answers the oldest request)
//   i_request_data    packed word of T_PER_WORD groups
//   o_valid, i_ready  element handshake toward the consumer
//   o_t, o_v, o_f     element fields; v/f get their dropped MSB back as 0
//   o_first, o_last   element index 0 / index T_size-1
// -----------------------------------------------------------------------------
module t_group_unpacker #(
  parameter int VEF_BIT    = 10,
  parameter int T_PER_WORD = 4,
  parameter int MAX_T_LOG  = 16,
  localparam int GRP  = 2 + 2 * (VEF_BIT - 1),
  localparam int WORD = GRP * T_PER_WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [MAX_T_LOG-1:0] i_T_size,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_sram_request,
  input  logic                 i_request_valid,
  input  logic [WORD-1:0]      i_request_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [1:0]           o_t,
  output logic [VEF_BIT-1:0]   o_v,
  output logic [VEF_BIT-1:0]   o_f,
  output logic                 o_first,
  output logic                 o_last
);

  localparam int GIDX_W = (T_PER_WORD > 1) ? $clog2(T_PER_WORD) : 1;
  localparam int SW     = VEF_BIT - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e state_q, state_d;

  logic [MAX_T_LOG-1:0] tSize_q;
  logic [MAX_T_LOG-1:0] wordsTotal_q;
  logic [MAX_T_LOG-1:0] wordsReq_q;
  logic [MAX_T_LOG-1:0] loadCnt_q;
  logic                 outstanding_q;
  logic [WORD-1:0]      fifoMem_q [2];
  logic                 wrPtr_q;
  logic                 rdPtr_q;
  logic [1:0]           count_q;
  logic [GIDX_W-1:0]    grpIdx_q;
  logic                 valid_q;
  logic                 first_q;
  logic                 last_q;
  logic [1:0]           t_q;
  logic [SW-1:0]        v_q;
  logic [SW-1:0]        f_q;

  logic           startAcc;
  logic           push;
  logic           load;
  logic           lastLoad;
  logic           pop;
  logic           lastHandshake;
  logic           reqCond;
  logic [GRP-1:0] headGroup;

  // Datapath qualifiers. A response only counts while a request is
  // outstanding, so stray or post-reset responses fall on the floor. Only one
  // request is ever in flight, hence a free FIFO slot is enough to ask again.
  always_comb begin
    startAcc      = (state_q == IDLE) && i_start;
    push          = i_request_valid && outstanding_q;
    lastLoad      = (loadCnt_q == tSize_q - MAX_T_LOG'(1));
    load          = (state_q == RUN) && (count_q != 2'd0) &&
                    (loadCnt_q != tSize_q) && (!valid_q || i_ready);
    pop           = load && (lastLoad || (grpIdx_q == GIDX_W'(T_PER_WORD - 1)));
    lastHandshake = valid_q && i_ready && last_q;
    reqCond       = (state_q == RUN) && (wordsReq_q < wordsTotal_q) &&
                    !outstanding_q && (count_q < 2'd2);
    headGroup     = fifoMem_q[rdPtr_q][int'(grpIdx_q) * GRP +: GRP];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A zero-length replay goes straight to DONE so the
  // caller still sees a done pulse without any SRAM traffic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = (i_T_size == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (lastHandshake) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-derived control outputs.
  always_comb begin
    o_busy         = (state_q != IDLE);
    o_done         = (state_q == DONE);
    o_sram_request = reqCond;
  end

  // Request bookkeeping, 2-word FIFO and the registered output stage. The
  // word at the FIFO head is popped when its last group is loaded, or early
  // when the final element of the replay lives in a partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      tSize_q       <= '0;
      wordsTotal_q  <= '0;
      wordsReq_q    <= '0;
      loadCnt_q     <= '0;
      outstanding_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifoMem_q[i] <= '0;
      end
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      count_q  <= 2'd0;
      grpIdx_q <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      t_q      <= '0;
      v_q      <= '0;
      f_q      <= '0;
    end else if (startAcc) begin
      tSize_q       <= i_T_size;
      wordsTotal_q  <= (i_T_size + MAX_T_LOG'(T_PER_WORD - 1)) / MAX_T_LOG'(T_PER_WORD);
      wordsReq_q    <= '0;
      loadCnt_q     <= '0;
      outstanding_q <= 1'b0;
      wrPtr_q       <= 1'b0;
      rdPtr_q       <= 1'b0;
      count_q       <= 2'd0;
      grpIdx_q      <= '0;
      valid_q       <= 1'b0;
    end else begin
      if (reqCond) begin
        wordsReq_q    <= wordsReq_q + MAX_T_LOG'(1);
        outstanding_q <= 1'b1;
      end else if (push) begin
        outstanding_q <= 1'b0;
      end
      if (push) begin
        fifoMem_q[wrPtr_q] <= i_request_data;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      if (load) begin
        valid_q   <= 1'b1;
        t_q       <= headGroup[GRP-1 -: 2];
        v_q       <= headGroup[2*SW-1 -: SW];
        f_q       <= headGroup[SW-1:0];
        first_q   <= (loadCnt_q == '0);
        last_q    <= lastLoad;
        loadCnt_q <= loadCnt_q + MAX_T_LOG'(1);
        grpIdx_q  <= pop ? '0 : grpIdx_q + GIDX_W'(1);
      end else if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_t     = t_q;
  assign o_v     = {1'b0, v_q};
  assign o_f     = {1'b0, f_q};
  assign o_first = first_q;
  assign o_last  = last_q;

endmodule

// File: tb/tb_t_group_unpacker.sv
// -----------------------------------------------------------------------------
// tb_t_group_unpacker
//
// Self-checking bench for t_group_unpacker. A behavioural SRAM responder and
// consumer drive the DUT; the expected element stream is taken straight from
// the packed words held in memWords (element i = word i/4, group i%4).
// -----------------------------------------------------------------------------
module tb_t_group_unpacker;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [15:0] i_T_size;
  logic        o_busy;
  logic        o_done;
  logic        o_sram_request;
  logic        i_request_valid;
  logic [79:0] i_request_data;
  logic        o_valid;
  logic        i_ready;
  logic [1:0]  o_t;
  logic [9:0]  o_v;
  logic [9:0]  o_f;
  logic        o_first;
  logic        o_last;

  int checks   = 0;
  int failures = 0;

  logic [79:0] memWords [32];

  int          gotN;
  logic [1:0]  gotT     [128];
  logic [9:0]  gotV     [128];
  logic [9:0]  gotF     [128];
  logic        gotFirst [128];
  logic        gotLast  [128];
  int          gotCyc   [128];
  int          reqCount;
  int          olapViol;
  int          stallViol;
  int          doneCycle;
  bit          timedOut;
  bit          busyAtDone;

  t_group_unpacker dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_T_size        (i_T_size),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_sram_request  (o_sram_request),
    .i_request_valid (i_request_valid),
    .i_request_data  (i_request_data),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_t             (o_t),
    .o_v             (o_v),
    .o_f             (o_f),
    .o_first         (o_first),
    .o_last          (o_last)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so a wedged DUT can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [79:0] randWord();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w[79:0];
  endfunction

  // Reference element: {t, v, f, first, last} straight from the packed words.
  function automatic logic [23:0] expElem(input int i, input int tSize);
    logic [79:0] w;
    logic [19:0] g;
    w = memWords[i / 4];
    g = w[(i % 4) * 20 +: 20];
    return {g[19:18], 1'b0, g[17:9], 1'b0, g[8:0], (i == 0), (i == tSize - 1)};
  endfunction

  function automatic logic [23:0] gotElem(input int i);
    return {gotT[i], gotV[i], gotF[i], gotFirst[i], gotLast[i]};
  endfunction

  // Starts a replay and plays SRAM responder plus consumer until o_done or the
  // cycle budget runs out. readyMode: 0 always ready, 1 toggling 1010, 2 random.
  // restartAt >= 0 pulses a second i_start (T_size 3) in that cycle.
  task automatic runStream(input int tSize, input int latency, input int readyMode,
                           input int restartAt, input int budget);
    int         pend;
    int         timer;
    int         reqIdx;
    int         respIdx;
    bit         prevStall;
    logic [1:0] pT;
    logic [9:0] pV;
    logic [9:0] pF;
    gotN = 0; reqCount = 0; olapViol = 0; stallViol = 0;
    doneCycle = -1; timedOut = 1; busyAtDone = 0;
    pend = 0; timer = 0; reqIdx = 0; respIdx = 0; prevStall = 0;
    pT = '0; pV = '0; pF = '0;
    @(negedge clk);
    i_start  = 1'b1;
    i_T_size = tSize[15:0];
    @(negedge clk);
    i_start = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (prevStall && (!o_valid || o_t !== pT || o_v !== pV || o_f !== pF)) stallViol++;
      if (o_done) begin
        doneCycle  = cyc;
        busyAtDone = o_busy;
        timedOut   = 0;
        break;
      end
      i_start  = (cyc == restartAt);
      i_T_size = 16'd3;
      case (readyMode)
        0:       i_ready = 1'b1;
        1:       i_ready = (cyc % 2 == 0);
        default: i_ready = $urandom_range(0, 1) == 1;
      endcase
      if (o_valid && i_ready) begin
        if (gotN < 128) begin
          gotT[gotN]     = o_t;
          gotV[gotN]     = o_v;
          gotF[gotN]     = o_f;
          gotFirst[gotN] = o_first;
          gotLast[gotN]  = o_last;
          gotCyc[gotN]   = cyc;
        end
        gotN++;
      end
      prevStall = o_valid && !i_ready;
      pT = o_t; pV = o_v; pF = o_f;
      i_request_valid = 1'b0;
      i_request_data  = randWord();
      if (pend != 0) begin
        timer--;
        if (timer <= 0) begin
          i_request_valid = 1'b1;
          i_request_data  = memWords[respIdx % 32];
          pend = 0;
        end
      end
      if (o_sram_request) begin
        if (pend != 0) olapViol++;
        reqCount++;
        pend    = 1;
        timer   = latency;
        respIdx = reqIdx;
        reqIdx++;
      end
    end
    i_start         = 1'b0;
    i_request_valid = 1'b0;
    i_ready         = 1'b0;
  endtask

  task automatic test_reset();
    logic [26:0] outs;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    outs = {o_busy, o_done, o_sram_request, o_valid, o_t, o_v, o_f, o_first, o_last};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h exp=0", outs);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_rate();
    for (int w = 0; w < 2; w++) memWords[w] = randWord();
    runStream(8, 1, 0, -1, 200);
    checks++;
    if (timedOut !== 1'b0) begin failures++; $display("[TB] FAIL t8_done got=timeout exp=done"); end
    checks++;
    if (gotN !== 8) begin failures++; $display("[TB] FAIL t8_count got=%0d exp=8", gotN); end
    checks++;
    if (reqCount !== 2) begin failures++; $display("[TB] FAIL t8_requests got=%0d exp=2", reqCount); end
    for (int i = 0; i < gotN && i < 8; i++) begin
      checks++;
      if (gotElem(i) !== expElem(i, 8)) begin
        failures++;
        $display("[TB] FAIL t8_elem%0d got=%h exp=%h", i, gotElem(i), expElem(i, 8));
      end
    end
    if (gotN == 8) begin
      checks++;
      if (gotCyc[7] - gotCyc[0] !== 7) begin
        failures++;
        $display("[TB] FAIL t8_back_to_back got=%0d exp=7", gotCyc[7] - gotCyc[0]);
      end
      checks++;
      if (doneCycle !== gotCyc[7] + 1) begin
        failures++;
        $display("[TB] FAIL t8_done_timing got=%0d exp=%0d", doneCycle, gotCyc[7] + 1);
      end
    end
    checks++;
    if (busyAtDone !== 1'b1) begin failures++; $display("[TB] FAIL t8_busy_in_done got=%0b exp=1", busyAtDone); end
    @(negedge clk);
    checks++;
    if ({o_done, o_busy} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL t8_idle_after got=%b exp=00", {o_done, o_busy});
    end
  endtask

  task automatic test_partial_word();
    memWords[0] = randWord();
    memWords[1] = randWord() | {20'h00001, 20'h00001, 20'h00001, 20'h00000};
    runStream(5, $urandom_range(1, 3), 2, -1, 400);
    checks++;
    if (timedOut !== 1'b0) begin failures++; $display("[TB] FAIL t5_done got=timeout exp=done"); end
    checks++;
    if (gotN !== 5) begin failures++; $display("[TB] FAIL t5_count got=%0d exp=5", gotN); end
    checks++;
    if (reqCount !== 2) begin failures++; $display("[TB] FAIL t5_requests got=%0d exp=2", reqCount); end
    for (int i = 0; i < gotN && i < 5; i++) begin
      checks++;
      if (gotElem(i) !== expElem(i, 5)) begin
        failures++;
        $display("[TB] FAIL t5_elem%0d got=%h exp=%h", i, gotElem(i), expElem(i, 5));
      end
    end
    i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL t5_stray_group got=%b exp=0", o_valid); end
    end
    i_ready = 1'b0;
  endtask

  task automatic test_field_values();
    memWords[0] = randWord();
    memWords[0][19:0] = {2'b10, 9'h1FF, 9'h003};
    runStream(1, 2, 0, -1, 100);
    checks++;
    if (gotN !== 1) begin failures++; $display("[TB] FAIL fields_count got=%0d exp=1", gotN); end
    checks++;
    if (gotElem(0) !== {2'd2, 10'h1FF, 10'h003, 1'b1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL fields_value got=%h exp=%h", gotElem(0), {2'd2, 10'h1FF, 10'h003, 1'b1, 1'b1});
    end
  endtask

  task automatic test_stall();
    int t;
    t = $urandom_range(9, 20);
    for (int w = 0; w < 5; w++) memWords[w] = randWord();
    runStream(t, 6, 1, -1, 600);
    checks++;
    if (timedOut !== 1'b0) begin failures++; $display("[TB] FAIL stall_done got=timeout exp=done"); end
    checks++;
    if (stallViol !== 0) begin failures++; $display("[TB] FAIL stall_stable got=%0d exp=0", stallViol); end
    checks++;
    if (olapViol !== 0) begin failures++; $display("[TB] FAIL stall_outstanding got=%0d exp=0", olapViol); end
    checks++;
    if (reqCount !== (t + 3) / 4) begin
      failures++;
      $display("[TB] FAIL stall_requests got=%0d exp=%0d", reqCount, (t + 3) / 4);
    end
    checks++;
    if (gotN !== t) begin failures++; $display("[TB] FAIL stall_count got=%0d exp=%0d", gotN, t); end
    for (int i = 0; i < gotN && i < t; i++) begin
      checks++;
      if (gotElem(i) !== expElem(i, t)) begin
        failures++;
        $display("[TB] FAIL stall_elem%0d got=%h exp=%h", i, gotElem(i), expElem(i, t));
      end
    end
  endtask

  task automatic test_zero_and_restart();
    runStream(0, 1, 0, -1, 20);
    checks++;
    if (reqCount !== 0) begin failures++; $display("[TB] FAIL zero_requests got=%0d exp=0", reqCount); end
    checks++;
    if (doneCycle !== 0) begin failures++; $display("[TB] FAIL zero_done_cycle got=%0d exp=0", doneCycle); end
    checks++;
    if (gotN !== 0) begin failures++; $display("[TB] FAIL zero_count got=%0d exp=0", gotN); end
    @(negedge clk);
    checks++;
    if ({o_done, o_busy} !== 2'b00) begin failures++; $display("[TB] FAIL zero_idle got=%b exp=00", {o_done, o_busy}); end
    for (int w = 0; w < 3; w++) memWords[w] = randWord();
    runStream(12, 2, 2, 5, 400);
    checks++;
    if (gotN !== 12) begin failures++; $display("[TB] FAIL restart_count got=%0d exp=12", gotN); end
    checks++;
    if (reqCount !== 3) begin failures++; $display("[TB] FAIL restart_requests got=%0d exp=3", reqCount); end
    for (int i = 0; i < gotN && i < 12; i++) begin
      checks++;
      if (gotElem(i) !== expElem(i, 12)) begin
        failures++;
        $display("[TB] FAIL restart_elem%0d got=%h exp=%h", i, gotElem(i), expElem(i, 12));
      end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    for (int run = 0; run < 3; run++) begin
      t = $urandom_range(1, 20);
      for (int w = 0; w < 5; w++) memWords[w] = randWord();
      runStream(t, $urandom_range(1, 3), 2, -1, 500);
      checks++;
      if (gotN !== t || olapViol !== 0 || timedOut !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b%0d_summary got=n%0d/ov%0d/to%0b exp=n%0d/ov0/to0", run, gotN, olapViol, timedOut, t);
      end
      for (int i = 0; i < gotN && i < t; i++) begin
        checks++;
        if (gotElem(i) !== expElem(i, t)) begin
          failures++;
          $display("[TB] FAIL b2b%0d_elem%0d got=%h exp=%h", run, i, gotElem(i), expElem(i, t));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit          seen;
    logic [26:0] outs;
    logic [2:0]  ctl;
    for (int w = 0; w < 4; w++) memWords[w] = randWord();
    i_ready = 1'b1;
    @(negedge clk);
    i_start  = 1'b1;
    i_T_size = 16'd16;
    @(negedge clk);
    i_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_sram_request) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_request got=none exp=request"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    outs = {o_busy, o_done, o_sram_request, o_valid, o_t, o_v, o_f, o_first, o_last};
    checks++;
    if (outs !== '0) begin failures++; $display("[TB] FAIL rstmid_outputs got=%h exp=0", outs); end
    i_request_valid = 1'b1;
    i_request_data  = memWords[0];
    @(negedge clk);
    i_request_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      ctl = {o_valid, o_sram_request, o_busy};
      checks++;
      if (ctl !== 3'b000) begin failures++; $display("[TB] FAIL rstmid_late_resp got=%b exp=000", ctl); end
      @(negedge clk);
    end
    i_ready = 1'b0;
    runStream(4, 1, 0, -1, 100);
    checks++;
    if (gotN !== 4) begin failures++; $display("[TB] FAIL rstmid_recover_count got=%0d exp=4", gotN); end
    for (int i = 0; i < gotN && i < 4; i++) begin
      checks++;
      if (gotElem(i) !== expElem(i, 4)) begin
        failures++;
        $display("[TB] FAIL rstmid_recover_elem%0d got=%h exp=%h", i, gotElem(i), expElem(i, 4));
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    i_start         = 1'b0;
    i_T_size        = '0;
    i_request_valid = 1'b0;
    i_request_data  = '0;
    i_ready         = 1'b0;
    test_reset();
    test_full_rate();
    test_partial_word();
    test_field_values();
    test_stall();
    test_zero_and_restart();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
